// File: rtl/jt053260_mixer.sv
// Four-channel PCM mixer with one shared multiplier. A mix takes 5 cen ticks from an accepted
// sample_stb to the sample pulse; sample_stb is dropped while busy, and cen=0 stalls the mix.
module jt053260_mixer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        sample_stb,
    input  logic [31:0] ch_snd,
    input  logic [27:0] ch_vol,
    input  logic [11:0] ch_pan,
    input  logic [3:0]  ch_en,
    output logic [15:0] snd_l,
    output logic [15:0] snd_r,
    output logic        sample,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CH0  = 3'd1,
        ST_CH1  = 3'd2,
        ST_CH2  = 3'd3,
        ST_CH3  = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    state_t             state_q, state_d;

    logic [31:0]        snd_q;
    logic [27:0]        vol_q;
    logic [11:0]        pan_q;
    logic [3:0]         en_q;

    logic signed [19:0] acc_l_q, acc_r_q;
    logic [15:0]        snd_l_q, snd_r_q;
    logic               sample_q;

    logic               start;
    logic [1:0]         sel;
    logic [7:0]         cur_snd;
    logic [6:0]         cur_vol;
    logic [2:0]         cur_pan;
    logic               cur_en;
    logic [2:0]         gain_l, gain_r;
    logic signed [14:0] prod;
    logic signed [17:0] mul_l, mul_r;
    logic signed [17:0] con_l, con_r;
    logic signed [19:0] shf_l, shf_r;
    logic [15:0]        sat_l, sat_r;

    // Acceptance ignores cen so a strobe is never missed between enable ticks.
    assign start = (state_q == ST_IDLE) && sample_stb;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sample_stb) state_d = ST_CH0;
            ST_CH0:  if (cen)        state_d = ST_CH1;
            ST_CH1:  if (cen)        state_d = ST_CH2;
            ST_CH2:  if (cen)        state_d = ST_CH3;
            ST_CH3:  if (cen)        state_d = ST_OUT;
            ST_OUT:  if (cen)        state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel = 2'd0;
        case (state_q)
            ST_CH1:  sel = 2'd1;
            ST_CH2:  sel = 2'd2;
            ST_CH3:  sel = 2'd3;
            default: sel = 2'd0;
        endcase
    end

    always_comb begin
        cur_snd = snd_q[7:0];
        cur_vol = vol_q[6:0];
        cur_pan = pan_q[2:0];
        cur_en  = en_q[0];
        case (sel)
            2'd1: begin
                cur_snd = snd_q[15:8];
                cur_vol = vol_q[13:7];
                cur_pan = pan_q[5:3];
                cur_en  = en_q[1];
            end
            2'd2: begin
                cur_snd = snd_q[23:16];
                cur_vol = vol_q[20:14];
                cur_pan = pan_q[8:6];
                cur_en  = en_q[2];
            end
            2'd3: begin
                cur_snd = snd_q[31:24];
                cur_vol = vol_q[27:21];
                cur_pan = pan_q[11:9];
                cur_en  = en_q[3];
            end
            default: ;
        endcase
    end

    // Pan code k splits a fixed total gain of 8 as (8-k, k); code 0 mutes.
    always_comb begin
        gain_l = 3'd0;
        gain_r = 3'd0;
        if (cur_pan != 3'd0) begin
            gain_l = 3'(4'd8 - {1'b0, cur_pan});
            gain_r = cur_pan;
        end
    end

    assign prod  = $signed({{7{cur_snd[7]}}, cur_snd}) * $signed({8'd0, cur_vol});
    assign mul_l = $signed({{3{prod[14]}}, prod}) * $signed({15'd0, gain_l});
    assign mul_r = $signed({{3{prod[14]}}, prod}) * $signed({15'd0, gain_r});
    assign con_l = cur_en ? mul_l : 18'sd0;
    assign con_r = cur_en ? mul_r : 18'sd0;

    assign shf_l = acc_l_q >>> 3;
    assign shf_r = acc_r_q >>> 3;

    always_comb begin
        sat_l = shf_l[15:0];
        if (shf_l > 20'sd32767)       sat_l = 16'h7FFF;
        else if (shf_l < -20'sd32768) sat_l = 16'h8000;
        sat_r = shf_r[15:0];
        if (shf_r > 20'sd32767)       sat_r = 16'h7FFF;
        else if (shf_r < -20'sd32768) sat_r = 16'h8000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            snd_q    <= '0;
            vol_q    <= '0;
            pan_q    <= '0;
            en_q     <= '0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            snd_l_q  <= '0;
            snd_r_q  <= '0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= 1'b0;
            if (start) begin
                snd_q   <= ch_snd;
                vol_q   <= ch_vol;
                pan_q   <= ch_pan;
                en_q    <= ch_en;
                acc_l_q <= '0;
                acc_r_q <= '0;
            end else if (cen) begin
                case (state_q)
                    ST_CH0, ST_CH1, ST_CH2, ST_CH3: begin
                        acc_l_q <= acc_l_q + {{2{con_l[17]}}, con_l};
                        acc_r_q <= acc_r_q + {{2{con_r[17]}}, con_r};
                    end
                    ST_OUT: begin
                        snd_l_q  <= sat_l;
                        snd_r_q  <= sat_r;
                        sample_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign snd_l  = snd_l_q;
    assign snd_r  = snd_r_q;
    assign sample = sample_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jt053260_mixer.sv
// Scoreboard bench for jt053260_mixer: a driver pushes expected mixes from an arithmetic model,
// a negedge monitor pops them on each sample pulse and checks output hold in between.
module tb_jt053260_mixer;

    logic        clk = 1'b0;
    logic        rst, cen, sample_stb;
    logic [31:0] ch_snd;
    logic [27:0] ch_vol;
    logic [11:0] ch_pan;
    logic [3:0]  ch_en;
    logic [15:0] snd_l, snd_r;
    logic        sample, busy;

    always #5 clk = ~clk;

    jt053260_mixer dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .sample_stb (sample_stb),
        .ch_snd     (ch_snd),
        .ch_vol     (ch_vol),
        .ch_pan     (ch_pan),
        .ch_en      (ch_en),
        .snd_l      (snd_l),
        .snd_r      (snd_r),
        .sample     (sample),
        .busy       (busy)
    );

    typedef struct {
        int l;
        int r;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   hold_l = 0;
    int   hold_r = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Reference mix: sum of snd*vol*gain per enabled channel, floor-divided by 8, then clipped.
    function automatic void model(input logic [31:0] s, input logic [27:0] v,
                                  input logic [11:0] p, input logic [3:0] e,
                                  output int l, output int r);
        int al, ar, sv, vv, k;
        al = 0;
        ar = 0;
        for (int c = 0; c < 4; c++) begin
            sv = $signed(s[8*c +: 8]);
            vv = int'(v[7*c +: 7]);
            k  = int'(p[3*c +: 3]);
            if (e[c] && k != 0) begin
                al += sv * vv * (8 - k);
                ar += sv * vv * k;
            end
        end
        l = sat16(al >>> 3);
        r = sat16(ar >>> 3);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            hold_l = 0;
            hold_r = 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (sample === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("snd_l", $signed(snd_l), mon_e.l);
                    chk("snd_r", $signed(snd_r), mon_e.r);
                    chk("sample_cycle", cyc, mon_e.cyc);
                    hold_l = mon_e.l;
                    hold_r = mon_e.r;
                end
            end else begin
                chk("hold_l", $signed(snd_l), hold_l);
                chk("hold_r", $signed(snd_r), hold_r);
            end
        end
    end

    // mode: 0 cen every clk, 1 cen one clk in three, 2 random cen.
    // stray: 0 none, 1 random extra strobes, 2 strobes during CH1 and on the OUT edge.
    // rst_at: nonzero asserts rst at that clk of the mix and abandons it.
    task automatic do_mix(input logic [31:0] s, input logic [27:0] v, input logic [11:0] p,
                          input logic [3:0] e, input int mode, input int stray, input int rst_at);
        bit   cen_seq [0:255];
        int   out_j, cnt, l, r;
        exp_t ex;
        cnt   = 0;
        out_j = 0;
        for (int j = 1; j < 256 && out_j == 0; j++) begin
            case (mode)
                0:       cen_seq[j] = 1'b1;
                1:       cen_seq[j] = (j % 3 == 0);
                default: cen_seq[j] = (j > 100) || ($urandom_range(0, 3) != 0);
            endcase
            if (cen_seq[j]) begin
                cnt++;
                if (cnt == 5) out_j = j;
            end
        end
        model(s, v, p, e, l, r);
        ch_snd     = s;
        ch_vol     = v;
        ch_pan     = p;
        ch_en      = e;
        sample_stb = 1'b1;
        cen        = 1'($urandom);
        if (rst_at == 0) begin
            ex.l   = l;
            ex.r   = r;
            ex.cyc = cyc + 1 + out_j;
            exp_q.push_back(ex);
        end
        @(negedge clk);
        chk("busy_before_start", busy, 0);
        @(posedge clk);
        #1;
        for (int j = 1; j <= out_j; j++) begin
            cen = cen_seq[j];
            if (stray == 1)      sample_stb = ($urandom_range(0, 2) == 0);
            else if (stray == 2) sample_stb = (j == 4 || j == out_j);
            else                 sample_stb = 1'b0;
            ch_snd = $urandom;
            ch_vol = 28'($urandom);
            ch_pan = 12'($urandom);
            ch_en  = 4'($urandom);
            if (j == 1) begin
                @(negedge clk);
                chk("busy_during_mix", busy, 1);
            end
            if (j == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst        = 1'b0;
                sample_stb = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        sample_stb = 1'b0;
    endtask

    task automatic idle(input int n, input bit cen_on);
        for (int i = 0; i < n; i++) begin
            sample_stb = 1'b0;
            cen        = cen_on ? 1'b1 : 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] rs;
    logic [27:0] rv;
    logic [11:0] rp;

    initial begin
        rst        = 1'b1;
        cen        = 1'b1;
        sample_stb = 1'b1;
        ch_snd     = $urandom;
        ch_vol     = 28'($urandom);
        ch_pan     = 12'($urandom);
        ch_en      = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b0;
        sample_stb = 1'b0;
        cen        = 1'b0;
        @(negedge clk);
        chk("reset_snd_l", $signed(snd_l), 0);
        chk("reset_snd_r", $signed(snd_r), 0);
        chk("reset_sample", sample, 0);
        chk("reset_busy", busy, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // ch0 +64, vol 127, centre pan; other channels carry noise but are disabled
        rs = $urandom; rs[7:0] = 8'd64;
        rv = 28'($urandom); rv[6:0] = 7'd127;
        rp = 12'($urandom); rp[2:0] = 3'd4;
        do_mix(rs, rv, rp, 4'b0001, 0, 0, 0);
        idle(2, 1'b0);

        // ch0 full negative, hard left pan
        rs[7:0] = 8'h80;
        rp[2:0] = 3'd1;
        do_mix(rs, rv, rp, 4'b0001, 0, 0, 0);
        idle(1, 1'b0);

        // all channels at maximum, left saturates
        do_mix(32'h7F7F7F7F, 28'hFFFFFFF, 12'b001_001_001_001, 4'hF, 0, 0, 0);
        idle(1, 1'b1);

        // muted by pan, then muted by enables
        do_mix($urandom, 28'($urandom), 12'h000, 4'hF, 2, 1, 0);
        do_mix(32'h7F7F7F7F, 28'hFFFFFFF, 12'($urandom), 4'h0, 0, 1, 0);
        idle(2, 1'b0);

        // slow cen with strobes during CH1 and on the OUT edge
        rs[7:0] = 8'd64;
        rp[2:0] = 3'd4;
        do_mix(rs, rv, rp, 4'b0001, 1, 2, 0);
        idle(8, 1'b1);

        // reset mid-CH2, then a strobe on the first clk after reset
        do_mix(32'h7F7F7F7F, 28'hFFFFFFF, 12'h249, 4'hF, 0, 0, 3);
        do_mix($urandom, 28'($urandom), 12'($urandom), 4'($urandom), 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            do_mix($urandom, 28'($urandom), 12'($urandom), 4'($urandom),
                   $urandom_range(0, 2), 1, 0);
            idle($urandom_range(0, 3), 1'b0);
        end

        idle(10, 1'b1);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jt053260_mixer.md
JT053260_MIXER -- requirements
Module: jt053260_mixer

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; every flop samples on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port cen, input, 1 bit: clock enable; the state machine advances only on clk edges with cen=1.
REQ-004 SHALL have port sample_stb, input, 1 bit: one-clk request to start a new mix.
REQ-005 SHALL have port ch_snd, input, 32 bits: four signed 8-bit channel samples; ch0 in [7:0], ch3 in [31:24].
REQ-006 SHALL have port ch_vol, input, 28 bits: four unsigned 7-bit volumes; ch0 in [6:0].
REQ-007 SHALL have port ch_pan, input, 12 bits: four 3-bit pan codes; ch0 in [2:0].
REQ-008 SHALL have port ch_en, input, 4 bits: channel-active flags from the PCM channels.
REQ-009 SHALL have port snd_l, output, 16 bits: signed left mix.
REQ-010 SHALL have port snd_r, output, 16 bits: signed right mix.
REQ-011 SHALL have port sample, output, 1 bit: one-clk pulse when snd_l and snd_r update.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state machine is not in IDLE.

Function
REQ-013 SHALL implement states IDLE, CH0, CH1, CH2, CH3 and OUT.
REQ-014 SHALL move IDLE->CH0 on any clk with sample_stb=1, regardless of cen, and SHALL latch ch_snd, ch_vol, ch_pan and ch_en on that clk.
REQ-015 SHALL clear both accumulators on the IDLE->CH0 transition.
REQ-016 SHALL move CH0->CH1->CH2->CH3->OUT->IDLE, one step per cen=1 clk.
REQ-017 SHALL, in CHn on a cen clk, add channel n's contribution to both accumulators.
REQ-018 SHALL share a single multiplier path across all four channels (time-multiplexed).
REQ-019 SHALL compute the base product as p = signed snd x unsigned vol, a 15-bit signed value.
REQ-020 SHALL apply pan gains as follows: code 0 gives gL=0, gR=0; code k in 1..7 gives gL=8-k, gR=k.
REQ-021 SHALL form the contributions p*gL and p*gR as 18-bit signed values.
REQ-022 SHALL make a channel's contribution 0 when its latched ch_en bit is 0.
REQ-023 SHALL use 20-bit signed accumulators, which cannot overflow.
REQ-024 SHALL, in OUT on a cen clk, set each output to saturate(acc >>> 3) within [-32768, 32767].
REQ-025 SHALL make the >>> 3 in REQ-024 an arithmetic shift (floor).
REQ-026 SHALL pulse sample for exactly one clk in OUT on that cen clk.
REQ-027 SHALL give a latency of 5 cen ticks from acceptance of sample_stb to the sample pulse.
REQ-028 SHALL hold snd_l and snd_r between updates.
REQ-029 SHALL ignore sample_stb while busy=1, with no queuing and no restart.
REQ-030 SHALL not let changes on the input buses after latching affect the mix in progress.
REQ-031 SHALL allow sample_stb in the same clk as the OUT->IDLE transition to be ignored; a new mix starts only from IDLE.
REQ-032 SHALL let cen=0 stall the machine indefinitely without losing state.

Reset
REQ-033 SHALL, when rst=1, force state to IDLE and set snd_l=0, snd_r=0, sample=0, busy=0, accumulators=0 and latched inputs=0.
REQ-034 SHALL give rst priority over sample_stb and cen.
REQ-035 SHALL discard any mix in progress on rst with no sample pulse.
REQ-036 SHALL accept a new sample_stb on the first clk after rst falls.

Verification
REQ-037 SHALL verify: rst pulse mid-CH2 -> busy=0, snd_l=snd_r=0 next clk, no sample pulse.
REQ-038 SHALL verify: ch0 snd=+64, vol=127, pan=4, ch_en=0001, cen=1 every clk -> sample 5 clks after stb; snd_l=snd_r=4064.
REQ-039 SHALL verify: ch0 snd=-128, vol=127, pan=1 -> snd_l=-14224, snd_r=-2032.
REQ-040 SHALL verify: all four channels snd=127, vol=127, pan=1, en=1111 -> snd_l=32767 (saturated), snd_r=8064.
REQ-041 SHALL verify: pan=0 or ch_en=0 on every channel -> snd_l=snd_r=0 with sample still pulsed.
REQ-042 SHALL verify: second stb during CH1, then cen at 1-in-3 clks -> exactly one sample pulse, 15 clks after the first stb, and input changes after latching have no effect.
